// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - instruction fetch: one outstanding imem read, {pc, instr} FIFO toward decode
module if_fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        fetch_stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    addr_q, addr_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [31:0]    pc_mem_q    [DEPTH];
    logic [31:0]    instr_mem_q [DEPTH];

    logic pop;
    logic push;
    logic accept;
    logic issue_ok;

    assign id_valid  = (count_q != '0);
    assign pop       = id_valid & id_ready;
    assign id_pc     = pc_mem_q[rptr_q];
    assign id_instr  = instr_mem_q[rptr_q];
    assign id_pc4    = id_pc + 32'd4;
    assign imem_req  = (state_q != IDLE);
    assign imem_addr = addr_q;

    // A new fetch may issue only if a FIFO slot can be reserved for it; in WAIT the
    // completing read already owns one slot, so one more must remain after this cycle's pop.
    always_comb begin
        issue_ok = 1'b0;
        case (state_q)
            IDLE:    issue_ok = (count_q < CW'(DEPTH));
            WAIT:    issue_ok = imem_ack && ((count_q - CW'(pop)) < CW'(DEPTH - 1));
            default: issue_ok = 1'b0;
        endcase
    end

    assign fetch_stall = ~issue_ok;
    assign accept      = pc_valid & ~flush & ~fetch_stall;

    // Request FSM: issue, complete (with back-to-back reissue), and drain a killed read.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        push    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = pc_in;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (flush) begin
                    state_d = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push = 1'b1;
                    if (accept) begin
                        addr_d = pc_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO bookkeeping; flush wipes occupancy and pointers ahead of any push or pop.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + PW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, address and pointer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; the pushed PC is the address the completing read was issued at.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]    <= '0;
                instr_mem_q[i] <= '0;
            end
        end else if (push) begin
            pc_mem_q[wptr_q]    <= addr_q;
            instr_mem_q[wptr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - self-checking bench for if_fetch_queue
module tb_if_fetch_queue;

    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        pc_valid;
    logic        fetch_stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;

    if_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .pc_valid   (pc_valid),
        .fetch_stall(fetch_stall),
        .flush      (flush),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_instr   (id_instr),
        .id_pc      (id_pc),
        .id_pc4     (id_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        int          lat;
        bit          pv;
        logic [31:0] pc;
        bit          fl;
        bit          rdy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        bit          e_stall;
    } vec_t;

    int          n_vec;
    int          n_err;
    int          lat;
    int          mem_cnt;
    int          pops;
    int          stalls;
    logic [31:0] exp_q[$];
    vec_t        tbl[$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    function automatic vec_t mk(input bit r, input int l, input bit pv, input logic [31:0] pc,
                                input bit fl, input bit rdy, input bit rq, input logic [31:0] ad,
                                input bit v, input logic [31:0] ip, input bit st);
        vec_t t;
        t.rst = r; t.lat = l; t.pv = pv; t.pc = pc; t.fl = fl; t.rdy = rdy;
        t.e_req = rq; t.e_addr = ad; t.e_valid = v; t.e_pc = ip; t.e_stall = st;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One clock: drive inputs after the edge, answer from the memory model, then sample and score.
    task automatic cycle(input bit pv, input logic [31:0] pc, input bit fl, input bit rdy);
        logic [31:0] e;
        @(posedge clk);
        #1;
        pc_valid = pv;
        pc_in    = pc;
        flush    = fl;
        id_ready = rdy;
        if (imem_req) begin
            if (mem_cnt >= lat) begin
                imem_ack   = 1'b1;
                imem_rdata = instr_of(imem_addr);
                mem_cnt    = 0;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 32'h0BAD_0BAD;
                mem_cnt++;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'h0BAD_0BAD;
            mem_cnt    = 0;
        end
        #1;
        if (id_valid && rdy) begin
            pops++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL sb_unexpected: got entry pc %h, expected none", id_pc);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", id_pc, e);
                check("sb_instr", id_instr, instr_of(e));
                check("sb_pc4", id_pc4, e + 32'd4);
            end
        end
        if (fl) exp_q.delete();
        else if (pv && !fetch_stall) exp_q.push_back(pc);
        if (fetch_stall) stalls++;
    endtask

    // Asynchronous reset pulse in mid-cycle; optionally check outputs while it is held.
    task automatic do_reset(input bit chk);
        reset    = 1'b1;
        pc_valid = 1'b0;
        flush    = 1'b0;
        imem_ack = 1'b0;
        id_ready = 1'b0;
        mem_cnt  = 0;
        exp_q.delete();
        #1;
        if (chk) begin
            check("rst_req", imem_req, 0);
            check("rst_addr", imem_addr, 0);
            check("rst_valid", id_valid, 0);
            check("rst_instr", id_instr, 0);
            check("rst_pc", id_pc, 0);
            check("rst_pc4", id_pc4, 32'h4);
        end
        #2;
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; lat = 0; mem_cnt = 0; pops = 0; stalls = 0;
        reset = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;

        // back-pressure then drain (lat 0)
        tbl.push_back(mk(1, 0, 1, 32'h00, 0, 0, 0, 32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h04, 0, 0, 1, 32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 0, 1, 32'h04, 1, 32'h00, 1));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 0, 0, 32'h04, 1, 32'h00, 1));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 0, 0, 32'h04, 1, 32'h00, 1));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 1, 0, 32'h04, 1, 32'h00, 1));
        tbl.push_back(mk(0, 0, 1, 32'h08, 0, 1, 0, 32'h04, 1, 32'h04, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 1, 1, 32'h08, 0, 32'h00, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 32'h08, 1, 32'h08, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 32'h08, 0, 32'h04, 0));
        // flush while read to 0x10 is in flight (3-cycle memory), refetch at 0x80
        tbl.push_back(mk(1, 2, 1, 32'h10, 0, 1, 0, 32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 2, 1, 32'h14, 1, 1, 1, 32'h10, 0, 32'h00, 1));
        tbl.push_back(mk(0, 2, 1, 32'h80, 0, 1, 1, 32'h10, 0, 32'h00, 1));
        tbl.push_back(mk(0, 2, 1, 32'h80, 1, 1, 1, 32'h10, 0, 32'h00, 1));
        tbl.push_back(mk(0, 2, 1, 32'h80, 0, 1, 0, 32'h10, 0, 32'h00, 0));
        tbl.push_back(mk(0, 2, 0, 32'h00, 0, 1, 1, 32'h80, 0, 32'h00, 1));
        tbl.push_back(mk(0, 2, 0, 32'h00, 0, 1, 1, 32'h80, 0, 32'h00, 1));
        tbl.push_back(mk(0, 2, 0, 32'h00, 0, 1, 1, 32'h80, 0, 32'h00, 0));
        tbl.push_back(mk(0, 2, 0, 32'h00, 0, 1, 0, 32'h80, 1, 32'h80, 0));
        tbl.push_back(mk(0, 2, 0, 32'h00, 0, 1, 0, 32'h80, 0, 32'h00, 0));
        // flush coincident with ack and pop at count 1
        tbl.push_back(mk(1, 0, 1, 32'h20, 0, 0, 0, 32'h00, 0, 32'h00, 0));
        tbl.push_back(mk(0, 0, 1, 32'h24, 0, 0, 1, 32'h20, 0, 32'h00, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 32'h24, 1, 32'h20, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 32'h24, 0, 32'h20, 0));
        tbl.push_back(mk(0, 0, 1, 32'h40, 0, 1, 0, 32'h24, 0, 32'h20, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 1, 1, 32'h40, 0, 32'h20, 0));
        tbl.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 32'h40, 1, 32'h40, 0));

        #2;
        check("por_req", imem_req, 0);
        check("por_valid", id_valid, 0);
        check("por_pc4", id_pc4, 32'h4);
        #5;
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset(0);
            lat = tbl[i].lat;
            cycle(tbl[i].pv, tbl[i].pc, tbl[i].fl, tbl[i].rdy);
            check($sformatf("v%0d_req", i), imem_req, tbl[i].e_req);
            check($sformatf("v%0d_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("v%0d_valid", i), id_valid, tbl[i].e_valid);
            check($sformatf("v%0d_pc", i), id_pc, tbl[i].e_pc);
            check($sformatf("v%0d_stall", i), fetch_stall, tbl[i].e_stall);
        end

        // streaming: zero-wait memory, 16 fetches, one per cycle after 2-cycle fill
        do_reset(0);
        lat = 0; pops = 0; stalls = 0;
        for (int i = 0; i < 16; i++) begin
            cycle(1, 32'(i * 4), 0, 1);
            if (i == 1) check("stream_fill0", pops, 0);
            if (i == 2) check("stream_fill1", pops, 1);
        end
        check("stream_stalls", stalls, 0);
        check("stream_pops15", pops, 14);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("stream_pops", pops, 16);

        // PC wrap at the top of the address space
        do_reset(0);
        lat = 0;
        cycle(1, 32'hFFFF_FFF8, 0, 0);
        cycle(1, 32'hFFFF_FFFC, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 1);
        check("wrap_valid", id_valid, 1);
        check("wrap_pc", id_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", id_pc4, 32'h0);

        // reset in the middle of an outstanding request with a non-empty FIFO
        do_reset(0);
        lat = 0;
        cycle(1, 32'h100, 0, 0);
        cycle(1, 32'h104, 0, 0);
        lat = 5;
        cycle(0, 0, 0, 0);
        check("mid_req", imem_req, 1);
        check("mid_valid", id_valid, 1);
        do_reset(1);
        cycle(0, 0, 0, 0);
        check("post_rst_req", imem_req, 0);
        check("post_rst_valid", id_valid, 0);

        // random traffic against the scoreboard
        do_reset(0);
        for (int i = 0; i < 600; i++) begin
            lat = int'($urandom_range(0, 2));
            cycle(($urandom_range(0, 9) < 7), {$urandom(), 2'b00} & 32'h0000_FFFC,
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6));
        end
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0 && !imem_req) break;
            cycle(0, 0, 0, 1);
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_req", imem_req, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
